// File: rtl/router_packet_sequencer.sv
// Automatic byte sequencer for the simple router: collects a 4-byte packet
// from the SPI receive side, strobes it into the router and reports the result.
module router_packet_sequencer #(
  parameter int SIZE    = 8,
  parameter int TIMEOUT = 255
) (
  input  logic          clock,
  input  logic          reset,
  input  logic          enable,
  input  logic          rxValid,
  input  logic [SIZE-1:0] rxByte,
  output logic          rxReady,
  output logic [SIZE:0] routerDataIn,
  output logic          writeDes,
  output logic          writeData,
  output logic          writeCheck,
  output logic          sendData,
  input  logic          port1,
  input  logic          port2,
  input  logic          errorFlag,
  output logic          busy,
  output logic          doneOk,
  output logic          doneErr,
  output logic          timeoutErr,
  output logic [7:0]    pktCount
);

  localparam int CW = $clog2(TIMEOUT + 1);

  localparam logic [3:0] IDLE     = 4'd0;
  localparam logic [3:0] DRV_DES  = 4'd1;
  localparam logic [3:0] RX_DATA  = 4'd2;
  localparam logic [3:0] DRV_DATA = 4'd3;
  localparam logic [3:0] RX_CHKL  = 4'd4;
  localparam logic [3:0] RX_CHKH  = 4'd5;
  localparam logic [3:0] DRV_CHK  = 4'd6;
  localparam logic [3:0] SEND     = 4'd7;
  localparam logic [3:0] WAIT     = 4'd8;

  localparam logic [CW-1:0] LAST_CNT = CW'(TIMEOUT - 1);

  logic [3:0]      state;
  logic [3:0]      nextState;
  logic [CW-1:0]   waitCnt;
  logic [SIZE-1:0] chkLo;
  logic            accept;
  logic            rxState;
  logic            waiting;
  logic            result;
  logic            exitEvt;
  logic            expire;

  assign rxState = (state == RX_DATA) || (state == RX_CHKL) ||
                   (state == RX_CHKH);
  assign rxReady = enable && ((state == IDLE) || rxState);
  assign accept  = rxValid && rxReady;
  assign waiting = rxState || (state == WAIT);
  assign result  = errorFlag || port1 || port2;
  assign exitEvt = (state == WAIT) ? result : accept;
  // Expiry only counts when nothing else ends the wait this cycle
  assign expire  = waiting && (waitCnt == LAST_CNT) && !exitEvt;

  assign busy       = (state != IDLE);
  assign writeDes   = enable && (state == DRV_DES);
  assign writeData  = enable && (state == DRV_DATA);
  assign writeCheck = enable && (state == DRV_CHK);
  assign sendData   = enable && (state == SEND);

  always_comb begin
    nextState = state;
    unique case (state)
      IDLE:     if (accept) nextState = DRV_DES;
      DRV_DES:  nextState = RX_DATA;
      RX_DATA:  if (accept) nextState = DRV_DATA;
      DRV_DATA: nextState = RX_CHKL;
      RX_CHKL:  if (accept) nextState = RX_CHKH;
      RX_CHKH:  if (accept) nextState = DRV_CHK;
      DRV_CHK:  nextState = SEND;
      SEND:     nextState = WAIT;
      WAIT:     if (result) nextState = IDLE;
      default:  nextState = IDLE;
    endcase
    if (expire) nextState = IDLE;
    if (!enable) nextState = IDLE;
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state        <= IDLE;
      waitCnt      <= '0;
      chkLo        <= '0;
      routerDataIn <= '0;
      doneOk       <= 1'b0;
      doneErr      <= 1'b0;
      timeoutErr   <= 1'b0;
      pktCount     <= '0;
    end else if (!enable) begin
      state        <= IDLE;
      waitCnt      <= '0;
      chkLo        <= '0;
      routerDataIn <= '0;
      doneOk       <= 1'b0;
      doneErr      <= 1'b0;
      timeoutErr   <= 1'b0;
    end else begin
      state      <= nextState;
      doneErr    <= (state == WAIT) && errorFlag;
      doneOk     <= (state == WAIT) && !errorFlag && (port1 || port2);
      timeoutErr <= expire;
      if ((state == WAIT) && !errorFlag && (port1 || port2))
        pktCount <= pktCount + 8'd1;
      if (nextState != state || !waiting)
        waitCnt <= '0;
      else
        waitCnt <= waitCnt + 1'b1;
      if (accept) begin
        unique case (state)
          RX_CHKL: chkLo        <= rxByte;
          RX_CHKH: routerDataIn <= {rxByte[0], chkLo};
          default: routerDataIn <= {1'b0, rxByte};
        endcase
      end
    end
  end

endmodule

// File: doc/router_packet_sequencer.md
# router_packet_sequencer

Sequencer that replaces the manual push-button flow of the simple router with an automatic one. It accepts a 4-byte packet from the SPI receive side: destination, data, checksum low byte and checksum high byte. It then drives the router's 9-bit data input and issues the write-destination, write-data, write-check and send strobes in order. Finally it waits for the router's port-1, port-2 or error result and reports the outcome, with a cycle timeout guarding both byte reception and the router response.

## Interface
- SIZE, 8, router data byte width; the router data bus is SIZE+1 bits.
- TIMEOUT, 255, maximum cycles to wait for the next byte mid-packet or for the router result; must be ≥1.
- clock  in  1  system clock; all logic is on the rising edge.
- reset  in  1  synchronous, active-high reset.
- enable  in  1  sequencer enable; low aborts any packet and holds the block in IDLE.
- rxValid  in  1  receive byte valid, from the SPI slave.
- rxByte  in  SIZE  received byte.
- rxReady  out  1  block can accept a byte this cycle.
- routerDataIn  out  SIZE+1  registered value presented to the router's dataIn.
- writeDes, writeData, writeCheck, sendData  out  1 each  one-cycle strobes to the router.
- port1, port2, errorFlag  in  1 each  router result levels.
- busy  out  1  high in every state except IDLE.
- doneOk, doneErr, timeoutErr  out  1 each  one-cycle outcome pulses.
- pktCount  out  8  count of packets that ended in doneOk; wraps 255→0.

## Operation
States:
- IDLE → DRV_DES → RX_DATA → DRV_DATA → RX_CHKL → RX_CHKH → DRV_CHK → SEND → WAIT → IDLE.

Byte acceptance:
- A byte is accepted when rxValid && rxReady.
- rxReady = enable && state ∈ {IDLE, RX_DATA, RX_CHKL, RX_CHKH}.

IDLE:
- An accepted byte is the destination.
- routerDataIn ← {1'b0, rxByte}; go to DRV_DES.

DRV_x states (one cycle each):
- DRV_DES pulses writeDes, then goes to RX_DATA.
- DRV_DATA pulses writeData, then goes to RX_CHKL.
- DRV_CHK pulses writeCheck, then goes to SEND.

RX states:
- RX_DATA: accepted byte → routerDataIn ← {1'b0, rxByte}; go to DRV_DATA.
- RX_CHKL: accepted byte is captured into an internal register; routerDataIn is unchanged; go to RX_CHKH.
- RX_CHKH: accepted byte → routerDataIn ← {rxByte[0], chkLo}; bits 7:1 are ignored; go to DRV_CHK.

SEND:
- One cycle; pulses sendData; go to WAIT.

WAIT:
- errorFlag → pulse doneErr.
- Else port1 | port2 → pulse doneOk and increment pktCount.
- Both exits go to IDLE.
- errorFlag has priority when it is sampled together with a port signal.

Timeout counter:
- Clears on every state change.
- Counts cycles spent in RX_DATA, RX_CHKL, RX_CHKH and WAIT.
- When it reaches TIMEOUT with no exit event: pulse timeoutErr and go to IDLE; no other done pulse is issued.

Abort (enable low in any state):
- Next state is IDLE; no done or timeout pulse.
- Strobes deassert and routerDataIn ← 0.
- Partial bytes are discarded.

Fixed rules:
- rxValid while rxReady is low is ignored; no buffering.
- routerDataIn holds its value between strobes.

## Timing
- Reset state: IDLE; routerDataIn=0; all strobes=0; done, error and timeout pulses=0; pktCount=0; busy=0; timeout counter=0.
- A byte accepted at edge k is visible on routerDataIn in cycle k+1.
  - For destination and data bytes, the matching strobe is high in that same cycle.
  - rxReady is high again in cycle k+2.
- Minimum packet: 4 accepted bytes plus DRV/SEND cycles; sendData is high 2 cycles after the RX_CHKH accept.
- WAIT samples its inputs starting the cycle after sendData; an outcome pulse appears one cycle after the sampled event.
- Timeout fires on the TIMEOUT-th consecutive waiting cycle.
  - A byte or result arriving in that same cycle wins over the timeout.
- reset has priority over enable; enable has priority over all transitions.

## Test plan
- Good packet: bytes 0x01, 0x2A, 0x2B, 0x00; router asserts port1 3 cycles after sendData.
  - Required: routerDataIn 0x001, then 0x02A, then 0x02B in order, with the matching strobes.
  - Required: doneOk pulses once and pktCount=1.
- Checksum high bit: bytes 0x02, 0xFF, 0x7F, 0x01.
  - Required: routerDataIn=0x17F during writeCheck.
- Error result: full packet, router raises errorFlag and port2 in the same cycle.
  - Required: doneErr only; pktCount unchanged.
- Timeouts with TIMEOUT=10:
  - Stall after the data byte → timeoutErr after 10 cycles in RX_CHKL, then IDLE with busy=0.
  - No router result → timeoutErr 10 cycles after entering WAIT.
- Abort: drop enable in RX_CHKH.
  - Required: IDLE next cycle, routerDataIn=0, no pulses.
  - Required: a following good packet completes normally.
- Back-to-back and reset:
  - 256 good packets → pktCount wraps to 0.
  - reset asserted during WAIT → all outputs at reset values next cycle.
